// File: rtl/symbol_slicer_decim_if.sv
`default_nettype none
// ============================================================================
// Module : symbol_slicer_decim_if
// Desc   : Sample-in / decision-out bundle of the symbol slicer-decimator.
// Rev    : 1.0
// ============================================================================
interface symbol_slicer_decim_if #(
  parameter int WIDTH = 18,
  parameter int OSR   = 4
);
  localparam int PW = $clog2(OSR);

  logic                   sam_clk_en;
  logic [PW-1:0]          phase_sel;
  logic signed [WIDTH-1:0] y_in;
  logic [1:0]             sym_out;
  logic                   sym_valid;
  logic signed [WIDTH-1:0] err_out;
  logic signed [WIDTH-1:0] ref_level;
  logic [2*WIDTH-1:0]     mse_out;
  logic                   mse_valid;

  modport master (
    output sam_clk_en, phase_sel, y_in,
    input  sym_out, sym_valid, err_out, ref_level, mse_out, mse_valid
  );

  modport slave (
    input  sam_clk_en, phase_sel, y_in,
    output sym_out, sym_valid, err_out, ref_level, mse_out, mse_valid
  );
endinterface
`default_nettype wire

// File: rtl/symbol_slicer_decim.sv
`default_nettype none
// ============================================================================
// Module : symbol_slicer_decim
// Desc   : OSR decimator + adaptive 4-ASK slicer; windowed MSE when
//          SLICER_MSE_EN is defined (otherwise mse_out/mse_valid tied 0).
// Rev    : 1.0
// ============================================================================
module symbol_slicer_decim #(
  parameter int                      WIDTH    = 18,
  parameter int                      OSR      = 4,
  parameter int                      LOG2_WIN = 4,
  parameter logic signed [WIDTH-1:0] REF_INIT = 18'sd65536
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  symbol_slicer_decim_if.slave bus
);
  localparam int PW = $clog2(OSR);
  localparam int XW = WIDTH + 2;
  localparam int AW = WIDTH + LOG2_WIN;
  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [XW-1:0]    X_MAX = XW'(S_MAX);
  localparam logic signed [XW-1:0]    X_MIN = XW'(S_MIN);

  logic [PW-1:0]           cnt_q, cnt_d;
  logic signed [WIDTH-1:0] s_q, s_d;
  logic                    s_vld_q, s_vld_d;
  logic [1:0]              sym_q, sym_d;
  logic signed [WIDTH-1:0] err_q, err_d;
  logic                    sym_vld_q, sym_vld_d;
  logic signed [WIDTH-1:0] ref_q, ref_d;
  logic [LOG2_WIN-1:0]     win_cnt_q, win_cnt_d;
  logic [AW-1:0]           abs_acc_q, abs_acc_d;

  logic signed [XW-1:0]    s_x, r_x, r3_x, lvl_x, diff_x;
  logic [1:0]              slice_sym;
  logic signed [WIDTH-1:0] slice_err;
  logic [WIDTH-1:0]        s_abs;
  logic [AW-1:0]           abs_tot;
  logic                    last_sym;

  // Slicer: two guard bits keep 3*ref and s-level exact before saturation.
  always_comb begin
    s_x  = XW'(s_q);
    r_x  = XW'(ref_q);
    r3_x = r_x + (r_x <<< 1);
    if (s_x >= r_x) begin
      slice_sym = 2'b11;
      lvl_x     = r3_x >>> 1;
    end else if (!s_q[WIDTH-1]) begin
      slice_sym = 2'b10;
      lvl_x     = r_x >>> 1;
    end else if (s_x >= -r_x) begin
      slice_sym = 2'b01;
      lvl_x     = -(r_x >>> 1);
    end else begin
      slice_sym = 2'b00;
      lvl_x     = -(r3_x >>> 1);
    end
    diff_x = s_x - lvl_x;
    if (diff_x > X_MAX) begin
      slice_err = S_MAX;
    end else if (diff_x < X_MIN) begin
      slice_err = S_MIN;
    end else begin
      slice_err = diff_x[WIDTH-1:0];
    end
    if (s_q == S_MIN) begin
      s_abs = S_MAX;
    end else if (s_q[WIDTH-1]) begin
      s_abs = -s_q;
    end else begin
      s_abs = s_q;
    end
    abs_tot  = abs_acc_q + AW'(s_abs);
    last_sym = &win_cnt_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    s_d       = s_q;
    s_vld_d   = 1'b0;
    sym_d     = sym_q;
    err_d     = err_q;
    sym_vld_d = 1'b0;
    ref_d     = ref_q;
    win_cnt_d = win_cnt_q;
    abs_acc_d = abs_acc_q;
    if (bus.sam_clk_en) begin
      cnt_d = cnt_q + PW'(1);
      if (cnt_q == bus.phase_sel) begin
        s_d     = bus.y_in;
        s_vld_d = 1'b1;
      end
    end
    if (s_vld_q) begin
      sym_d     = slice_sym;
      err_d     = slice_err;
      sym_vld_d = 1'b1;
      win_cnt_d = win_cnt_q + LOG2_WIN'(1);
      // New reference lands with this decision, so it first slices the next window.
      if (last_sym) begin
        ref_d     = $signed(abs_tot[AW-1:LOG2_WIN]);
        abs_acc_d = '0;
      end else begin
        abs_acc_d = abs_tot;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt_q     <= '0;
      s_q       <= '0;
      s_vld_q   <= 1'b0;
      sym_q     <= '0;
      err_q     <= '0;
      sym_vld_q <= 1'b0;
      ref_q     <= REF_INIT;
      win_cnt_q <= '0;
      abs_acc_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      s_vld_q   <= s_vld_d;
      sym_q     <= sym_d;
      err_q     <= err_d;
      sym_vld_q <= sym_vld_d;
      ref_q     <= ref_d;
      win_cnt_q <= win_cnt_d;
      abs_acc_q <= abs_acc_d;
    end
  end

  assign bus.sym_out   = sym_q;
  assign bus.sym_valid = sym_vld_q;
  assign bus.err_out   = err_q;
  assign bus.ref_level = ref_q;

`ifdef SLICER_MSE_EN
  localparam int QW = 2*WIDTH + LOG2_WIN;

  logic signed [2*WIDTH-1:0] sq;
  logic [QW-1:0]             sq_tot, sq_acc_q, sq_acc_d;
  logic [2*WIDTH-1:0]        mse_q, mse_d;
  logic                      mse_vld_q, mse_vld_d;

  always_comb begin
    sq        = slice_err * slice_err;
    sq_tot    = sq_acc_q + QW'($unsigned(sq));
    sq_acc_d  = sq_acc_q;
    mse_d     = mse_q;
    mse_vld_d = 1'b0;
    if (s_vld_q) begin
      if (last_sym) begin
        mse_d     = sq_tot[QW-1:LOG2_WIN];
        mse_vld_d = 1'b1;
        sq_acc_d  = '0;
      end else begin
        sq_acc_d  = sq_tot;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sq_acc_q  <= '0;
      mse_q     <= '0;
      mse_vld_q <= 1'b0;
    end else begin
      sq_acc_q  <= sq_acc_d;
      mse_q     <= mse_d;
      mse_vld_q <= mse_vld_d;
    end
  end

  assign bus.mse_out   = mse_q;
  assign bus.mse_valid = mse_vld_q;
`else
  assign bus.mse_out   = '0;
  assign bus.mse_valid = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_symbol_slicer_decim.sv
`default_nettype none
// ============================================================================
// Module : tb_symbol_slicer_decim
// Desc   : Directed bench for symbol_slicer_decim with a per-cycle reference model.
// Rev    : 1.0
// ============================================================================
module tb_symbol_slicer_decim;
  localparam int WIDTH    = 18;
  localparam int OSR      = 4;
  localparam int LOG2_WIN = 4;
  localparam int WIN      = 16;
  localparam int REF_INIT = 65536;
  localparam int SMAX     = 131071;
  localparam int SMIN     = -131072;
`ifdef SLICER_MSE_EN
  localparam bit MSE_EN = 1'b1;
`else
  localparam bit MSE_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  symbol_slicer_decim_if #(.WIDTH(WIDTH), .OSR(OSR)) bus ();

  symbol_slicer_decim #(
    .WIDTH(WIDTH), .OSR(OSR), .LOG2_WIN(LOG2_WIN), .REF_INIT(18'sd65536)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: decisions from the sample stream using the slicing rules directly.
  bit     started = 1'b0;
  int     en_cnt;
  bit     pend;
  int     pend_s;
  int     m_ref, m_sym, m_err, m_symv, m_msev;
  longint m_mse, abs_sum, sq_sum;
  int     win_n;

  always @(posedge sys_clk) begin
    int s, lvl, e, a;
    if (reset) begin
      started = 1'b1;
      en_cnt = 0; pend = 1'b0; pend_s = 0;
      m_ref = REF_INIT; m_sym = 0; m_err = 0; m_symv = 0; m_msev = 0; m_mse = 0;
      abs_sum = 0; sq_sum = 0; win_n = 0;
    end else begin
      m_symv = 0;
      m_msev = 0;
      if (pend) begin
        s = pend_s;
        if (s >= m_ref)       begin m_sym = 3; lvl = (3 * m_ref) / 2;  end
        else if (s >= 0)      begin m_sym = 2; lvl = m_ref / 2;        end
        else if (s >= -m_ref) begin m_sym = 1; lvl = -(m_ref / 2);     end
        else                  begin m_sym = 0; lvl = -((3 * m_ref) / 2); end
        e = s - lvl;
        if (e > SMAX) e = SMAX;
        if (e < SMIN) e = SMIN;
        m_err = e;
        m_symv = 1;
        a = (s < 0) ? -s : s;
        if (a > SMAX) a = SMAX;
        abs_sum += a;
        sq_sum  += longint'(e) * longint'(e);
        win_n++;
        if (win_n == WIN) begin
          m_ref = int'(abs_sum / WIN);
          if (MSE_EN) begin
            m_mse  = sq_sum / WIN;
            m_msev = 1;
          end
          abs_sum = 0; sq_sum = 0; win_n = 0;
        end
        pend = 1'b0;
      end
      if (bus.sam_clk_en) begin
        if ((en_cnt % OSR) == int'(bus.phase_sel)) begin
          pend   = 1'b1;
          pend_s = int'($signed(bus.y_in));
        end
        en_cnt++;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (started) begin
      chk("sym_valid", longint'(bus.sym_valid), longint'(m_symv));
      chk("sym_out",   longint'(bus.sym_out),   longint'(m_sym));
      chk("err_out",   longint'($signed(bus.err_out)),   longint'(m_err));
      chk("ref_level", longint'($signed(bus.ref_level)), longint'(m_ref));
      chk("mse_valid", longint'(bus.mse_valid), longint'(m_msev));
      chk("mse_out",   longint'(bus.mse_out),   m_mse);
    end
  end

  // Observation log for the literal expectations.
  int     cyc, nsym, nmse, mse_at;
  int     sym_v [64];
  int     err_v [64];
  int     sym_c [64];
  longint g_mse;

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
    if (bus.sym_valid) begin
      if (nsym < 64) begin
        sym_v[nsym] = int'(bus.sym_out);
        err_v[nsym] = int'($signed(bus.err_out));
        sym_c[nsym] = cyc;
      end
      nsym++;
      if (bus.mse_valid) mse_at = nsym;
    end
    if (bus.mse_valid) begin
      nmse++;
      g_mse = longint'(bus.mse_out);
    end
  endtask

  task automatic clear_log();
    cyc = 0; nsym = 0; nmse = 0; mse_at = 0; g_mse = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.sam_clk_en = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic send(input int y);
    logic [31:0] yv;
    yv = y;
    for (int i = 0; i < OSR; i++) begin
      bus.sam_clk_en = 1'b1;
      bus.y_in = yv[WIDTH-1:0];
      tick();
    end
    bus.sam_clk_en = 1'b0;
  endtask

  task automatic flush();
    bus.sam_clk_en = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    bus.sam_clk_en = 1'b0;
    bus.phase_sel  = 2'd2;
    bus.y_in       = '0;
    clear_log();

    // Reset values
    do_reset(3);
    chk("rst sym_out",   longint'(bus.sym_out), 0);
    chk("rst err_out",   longint'($signed(bus.err_out)), 0);
    chk("rst sym_valid", longint'(bus.sym_valid), 0);
    chk("rst mse_valid", longint'(bus.mse_valid), 0);
    chk("rst mse_out",   longint'(bus.mse_out), 0);
    chk("rst ref_level", longint'($signed(bus.ref_level)), REF_INIT);

    // Decimation timing with y_in = cycle index
    for (int k = 0; k < 12; k++) begin
      bus.sam_clk_en = 1'b1;
      bus.y_in = WIDTH'(k);
      tick();
    end
    bus.sam_clk_en = 1'b0;
    chk("t2 nsym",     nsym, 3);
    chk("t2 cyc0",     sym_c[0], 4);
    chk("t2 cyc1",     sym_c[1], 8);
    chk("t2 sym0",     sym_v[0], 2);
    chk("t2 err0",     err_v[0], -32766);
    chk("t2 err1",     err_v[1], -32762);

    // Slicer decisions at ref 65536
    do_reset(2);
    send(98304); send(40000); send(-131072); send(-65536);
    flush();
    chk("t3 sym0", sym_v[0], 3); chk("t3 err0", err_v[0], 0);
    chk("t3 sym1", sym_v[1], 2); chk("t3 err1", err_v[1], 7232);
    chk("t3 sym2", sym_v[2], 0); chk("t3 err2", err_v[2], -32768);
    chk("t3 sym3", sym_v[3], 1); chk("t3 err3", err_v[3], -32768);

    // Full window of +/-49152, then slice with the adapted reference
    do_reset(2);
    for (int i = 0; i < WIN; i++) send((i % 2 == 0) ? 49152 : -49152);
    flush();
    chk("t4 nmse",    nmse, MSE_EN ? 1 : 0);
    chk("t4 mse_at",  mse_at, MSE_EN ? 16 : 0);
    chk("t4 mse_out", longint'(bus.mse_out), MSE_EN ? 268435456 : 0);
    chk("t4 ref",     longint'($signed(bus.ref_level)), 49152);
    send(49152);
    flush();
    chk("t4 sym16", sym_v[16], 3);
    chk("t4 err16", err_v[16], -24576);

    // Reset mid-window discards the partial window
    do_reset(2);
    for (int i = 0; i < 10; i++) send(20000);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("t5 no mse", nmse, 0);
    chk("t5 ref",    longint'($signed(bus.ref_level)), REF_INIT);
    clear_log();
    for (int i = 0; i < WIN; i++) send(30000);
    flush();
    chk("t5 nsym",   nsym, 16);
    chk("t5 nmse",   nmse, MSE_EN ? 1 : 0);
    chk("t5 mse_at", mse_at, MSE_EN ? 16 : 0);
    chk("t5 ref2",   longint'($signed(bus.ref_level)), 30000);

    // Zero reference: levels collapse to 0
    for (int i = 0; i < WIN; i++) send(0);
    flush();
    chk("ref0 ref", longint'($signed(bus.ref_level)), 0);
    send(0); send(-1);
    flush();
    chk("ref0 sym32", sym_v[32], 3); chk("ref0 err32", err_v[32], 0);
    chk("ref0 sym33", sym_v[33], 0); chk("ref0 err33", err_v[33], -1);

    // |-2^17| saturates to 2^17-1
    do_reset(2);
    for (int i = 0; i < WIN; i++) send(SMIN);
    flush();
    chk("abs sat ref", longint'($signed(bus.ref_level)), SMAX);

    // Other phases and gapped strobes, checked against the model only
    bus.phase_sel = 2'd0;
    send(70000); send(-20000); send(131071);
    bus.phase_sel = 2'd3;
    send(-90000); send(5000);
    for (int i = 0; i < 24; i++) begin
      bus.sam_clk_en = (i % 3 != 0);
      bus.y_in = WIDTH'(i * 4000 - 40000);
      if (i == 12) bus.phase_sel = 2'd1;
      tick();
    end
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
